// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared constants for the GPIO bus arbiter: AHB-lite transfer types and
// the arbiter FSM state encoding.
package gpio_bus_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers which master to favour
// on a tie and only moves when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic fav_m1;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = fav_m1 ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      fav_m1 <= 1'b0;
        else if (gnt[0]) fav_m1 <= 1'b1;
        else if (gnt[1]) fav_m1 <= 1'b0;
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Arbitrates two GPIO masters onto one AHB-lite slave port, one transfer at a
// time: grant in IDLE, address phase, data phase, then done.
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_done,
    output logic              m1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              HSEL,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [1:0]        dbg_state
);

    // Handshake: a master holds req (and its write/addr/wdata) until it sees
    // its one-cycle gnt; the request is captured on that edge. A req still
    // high afterwards is a fresh request, served once the arbiter is IDLE.

    arb_state_e        state, state_nxt;
    logic [1:0]        gnt;
    logic [1:0]        done_q;
    logic              owner;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;

    rr_arb2 u_rr_arb2 (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .req   ({m1_req, m0_req}),
        .en    ((state == ST_IDLE) && HRESETn),
        .gnt   (gnt)
    );

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign dbg_state = state;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        HSEL      = 1'b0;
        HTRANS    = HTRANS_IDLE;
        HWRITE    = 1'b0;
        case (state)
            ST_IDLE: if (m0_req || m1_req) state_nxt = ST_ADDR;
            ST_ADDR: begin
                state_nxt = ST_DATA;
                HSEL      = 1'b1;
                HTRANS    = HTRANS_NONSEQ;
                HWRITE    = wr_q;
            end
            ST_DATA: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // HADDR doubles as the latched address: it only moves on the grant edge,
    // so it holds its value everywhere outside the address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            HADDR   <= '0;
            HWDATA  <= '0;
            rdata   <= '0;
            done_q  <= 2'b00;
        end else begin
            done_q <= 2'b00;
            if (gnt[0] || gnt[1]) begin
                owner   <= gnt[1];
                wr_q    <= gnt[1] ? m1_write : m0_write;
                HADDR   <= gnt[1] ? m1_addr  : m0_addr;
                wdata_q <= gnt[1] ? m1_wdata : m0_wdata;
            end
            if (state == ST_ADDR) HWDATA <= wdata_q;
            if (state == ST_DATA) begin
                if (!wr_q) rdata <= HRDATA;
                done_q[owner] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle by a transfer-level model.
module tb_gpio_bus_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              m0_req = 1'b0, m1_req = 1'b0;
    logic              m0_write = 1'b0, m1_write = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
    logic              m0_gnt, m1_gnt, m0_done, m1_done;
    logic [DATA_W-1:0] rdata;
    logic              HSEL, HWRITE;
    logic [1:0]        HTRANS;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA = '0;
    logic [1:0]        dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    gpio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .rdata(rdata), .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .dbg_state(dbg_state)
    );

    // clock / reset
    initial forever #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // inputs only ever change 1 time unit after a rising edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transfer-level reference model. A transfer granted at cycle T occupies
    // the bus for T+1 (address) and T+2 (data); done/rdata show at T+3, which
    // is also the earliest cycle another grant can occur.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] exp_q[$];
    bit                m_active = 0;
    int                m_tg = 0;
    bit                m_owner = 0, m_wr = 0, m_fav_m1 = 0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [ADDR_W-1:0] e_haddr = '0;
    logic [DATA_W-1:0] e_hwdata = '0, e_rdata = '0;

    always @(negedge HCLK) begin
        int t;
        bit free;
        logic [1:0] e_gnt, e_done;
        if (!HRESETn) begin
            chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
            chk("rst_done", {m1_done, m0_done}, 0);
            chk("rst_bus", {HSEL, HWRITE, HTRANS}, 0);
            chk("rst_haddr", HADDR, 0);
            chk("rst_hwdata", HWDATA, 0);
            chk("rst_rdata", rdata, 0);
            m_active = 0; m_fav_m1 = 0;
            e_haddr = '0; e_hwdata = '0; e_rdata = '0;
            exp_q.delete();
        end else begin
            t = m_active ? cyc - m_tg : 99;
            free = !m_active || t >= 3;
            e_gnt = 2'b00;
            if (free) begin
                if (m0_req && m1_req) e_gnt = m_fav_m1 ? 2'b10 : 2'b01;
                else                  e_gnt = {m1_req, m0_req};
            end
            e_done = (m_active && t == 3) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            if (m_active && t == 3 && !m_wr && exp_q.size() > 0) e_rdata = exp_q.pop_front();

            chk("gnt", {m1_gnt, m0_gnt}, e_gnt);
            chk("done", {m1_done, m0_done}, e_done);
            chk("hsel", HSEL, (t == 1));
            chk("htrans", HTRANS, (t == 1) ? 2'b10 : 2'b00);
            chk("hwrite", HWRITE, (t == 1) && m_wr);
            chk("haddr", HADDR, e_haddr);
            chk("hwdata", HWDATA, e_hwdata);
            chk("rdata", rdata, e_rdata);

            if (m_active && t == 2 && !m_wr) exp_q.push_back(HRDATA);
            if (m_active && t == 1) e_hwdata = m_wdata;
            if (e_gnt != 2'b00) begin
                m_active = 1;
                m_tg     = cyc;
                m_owner  = e_gnt[1];
                m_wr     = e_gnt[1] ? m1_write : m0_write;
                e_haddr  = e_gnt[1] ? m1_addr : m0_addr;
                m_wdata  = e_gnt[1] ? m1_wdata : m0_wdata;
                m_fav_m1 = e_gnt[0];
            end else if (m_active && t >= 3) begin
                m_active = 0;
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus: directed scenarios, then randomized traffic
    // ------------------------------------------------------------------
    initial begin
        bit g0, g1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("lit_reset_hsel", HSEL, 0);
        chk("lit_reset_rdata", rdata, 0);
        tick();
        HRESETn = 1'b1;

        // m0 read of register 1
        m0_req = 1; m0_write = 0; m0_addr = 4'h1; HRDATA = 32'h0000_A5A5;
        @(negedge HCLK); chk("lit_rd_gnt", m0_gnt, 1);
        tick(); m0_req = 0;
        @(negedge HCLK);
        chk("lit_rd_hsel", HSEL, 1); chk("lit_rd_haddr", HADDR, 4'h1); chk("lit_rd_htrans", HTRANS, 2);
        tick(); tick();
        @(negedge HCLK);
        chk("lit_rd_done", m0_done, 1); chk("lit_rd_rdata", rdata, 32'h0000_A5A5);
        tick();

        // m1 write of 0xFF to register 2
        m1_req = 1; m1_write = 1; m1_addr = 4'h2; m1_wdata = 32'h0000_00FF;
        @(negedge HCLK); chk("lit_wr_gnt", m1_gnt, 1);
        tick(); m1_req = 0;
        @(negedge HCLK); chk("lit_wr_hwrite", HWRITE, 1);
        tick();
        @(negedge HCLK); chk("lit_wr_hwdata", HWDATA, 32'h0000_00FF);
        tick();
        @(negedge HCLK); chk("lit_wr_done", m1_done, 1); chk("lit_wr_rdata", rdata, 32'h0000_A5A5);
        tick();

        // both held after a reset: m0, m1, m0 at T, T+3, T+6
        HRESETn = 0; tick(); HRESETn = 1;
        m0_req = 1; m1_req = 1; m0_write = 0; m1_write = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge HCLK);
            if (k == 0) chk("lit_rr_t0", {m1_gnt, m0_gnt}, 2'b01);
            if (k == 3) chk("lit_rr_t3", {m1_gnt, m0_gnt}, 2'b10);
            if (k == 6) chk("lit_rr_t6", {m1_gnt, m0_gnt}, 2'b01);
            tick();
        end
        m0_req = 0; m1_req = 0;
        tick(); tick();

        // m1 arrives during m0's address phase
        m0_req = 1; m0_write = 1; m0_addr = 4'h5; m0_wdata = 32'h1234_5678;
        @(negedge HCLK); chk("lit_pre_gnt0", m0_gnt, 1);
        tick(); m0_req = 0; m1_req = 1; m1_write = 0; m1_addr = 4'h9;
        @(negedge HCLK); chk("lit_pre_nogrant_a", m1_gnt, 0); chk("lit_pre_haddr", HADDR, 4'h5);
        tick();
        @(negedge HCLK); chk("lit_pre_nogrant_d", m1_gnt, 0); chk("lit_pre_hwdata", HWDATA, 32'h1234_5678);
        tick();
        @(negedge HCLK); chk("lit_pre_gnt1", m1_gnt, 1); chk("lit_pre_done0", m0_done, 1);
        tick(); m1_req = 0;
        repeat (3) tick();

        // reset during the data phase
        m0_req = 1; m0_write = 1; m0_addr = 4'h3; m0_wdata = 32'h0000_DEAD;
        @(negedge HCLK); chk("lit_abort_gnt", m0_gnt, 1);
        tick(); m0_req = 0;
        tick(); HRESETn = 0;
        @(negedge HCLK); chk("lit_abort_hwdata", HWDATA, 0); chk("lit_abort_haddr", HADDR, 0);
        tick(); HRESETn = 1;
        @(negedge HCLK); chk("lit_abort_nodone", {m1_done, m0_done}, 0); chk("lit_abort_hsel", HSEL, 0);
        tick();
        m1_req = 1; m1_write = 0; m1_addr = 4'h7;
        @(negedge HCLK); chk("lit_abort_next_gnt", m1_gnt, 1);
        tick(); m1_req = 0;
        tick(); tick();
        @(negedge HCLK); chk("lit_abort_next_done", m1_done, 1);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge HCLK);
            g0 = m0_gnt; g1 = m1_gnt;
            tick();
            HRDATA = $urandom;
            if (!HRESETn) HRESETn = 1;
            else if ($urandom_range(0, 299) == 0) HRESETn = 0;
            if (m0_req && g0) m0_req = ($urandom_range(0, 1) == 1);
            else if (!m0_req) m0_req = ($urandom_range(0, 9) < 4);
            if (m0_req && (g0 || !m0_req)) ;
            if (g0 || !m0_req) begin
                m0_write = 1'($urandom_range(0, 1));
                m0_addr  = 4'($urandom_range(0, 15));
                m0_wdata = $urandom;
            end
            if (m1_req && g1) m1_req = ($urandom_range(0, 1) == 1);
            else if (!m1_req) m1_req = ($urandom_range(0, 9) < 4);
            if (g1 || !m1_req) begin
                m1_write = 1'($urandom_range(0, 1));
                m1_addr  = 4'($urandom_range(0, 15));
                m1_wdata = $urandom;
            end
        end

        m0_req = 0; m1_req = 0;
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
